// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types
//   Shared types for the pipelined LC-3b core. This slice holds what the
//   cache/memory arbiter needs:
//     lc3b_line    - one 128-bit cache line
//     arb_state_t  - arbiter states (IDLE, SERVE_I, SERVE_D)
//     arb_owner_t  - which cache owns (or last owned) the memory port
//     dcache_wins  - grant decision when the port is idle
// ---------------------------------------------------------------------------
package lc3b_types;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

  // dcache takes the port when it is pending and either icache is not
  // pending or dcache currently holds priority.
  function automatic logic dcache_wins(input logic i_pending,
                                       input logic d_pending,
                                       input logic prefer_d);
    return d_pending && (!i_pending || prefer_d);
  endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
//   Shares the single physical memory port between the icache (line reads)
//   and the dcache (line reads and writebacks). One line transaction is
//   in flight at a time; the address, writeback data and operation are
//   captured at grant so memory sees stable signals until pmem_resp, and
//   the completion pulse goes back to the owning cache only.
//
//   Configuration macro:
//     ARB_ROUND_ROBIN_EN - when defined, a last_grant flop alternates
//                          priority when both caches contend; when
//                          undefined, dcache always beats icache.
//
//   Ports:
//     clk, reset                     clock, async active-high reset
//     icache_read/address            icache line read request
//     icache_rdata/resp              read line and completion pulse to icache
//     dcache_read/write/address/wdata dcache read / writeback request
//     dcache_rdata/resp              read line and completion pulse to dcache
//     pmem_read/write                registered memory strobes
//     pmem_address/wdata             captured transaction attributes
//     pmem_rdata/resp                memory read data and completion pulse
//     arb_busy                       high while a transaction is owned
// ---------------------------------------------------------------------------
module cache_mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  icache_read,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,

  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,

  output logic                  arb_busy
);

  arb_state_t state, next_state;

  logic i_pending;
  logic d_pending;
  logic prefer_d;
  logic grant_i;
  logic grant_d;

  assign i_pending = icache_read;
  assign d_pending = dcache_read | dcache_write;

  // -------------------------------------------------------------------------
  // Priority source
  // -------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= OWNER_I;
    end else if (grant_d) begin
      last_grant <= OWNER_D;
    end else if (grant_i) begin
      last_grant <= OWNER_I;
    end
  end

  // Whoever was not served last wins a tie.
  assign prefer_d = (last_grant == OWNER_I);
`else
  assign prefer_d = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: state flops use non-blocking (<=) so every flop samples values
  // from before the edge; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // -------------------------------------------------------------------------
  // Next state, grant decode and completion pulses
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    next_state  = state;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    icache_resp = 1'b0;
    dcache_resp = 1'b0;

    unique case (state)
      IDLE: begin
        // pmem_resp is deliberately ignored here: nothing is in flight.
        if (dcache_wins(i_pending, d_pending, prefer_d)) begin
          grant_d    = 1'b1;
          next_state = SERVE_D;
        end else if (i_pending) begin
          grant_i    = 1'b1;
          next_state = SERVE_I;
        end
      end

      SERVE_I: begin
        if (pmem_resp) begin
          icache_resp = 1'b1;
          next_state  = IDLE;
        end
      end

      SERVE_D: begin
        if (pmem_resp) begin
          dcache_resp = 1'b1;
          next_state  = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Memory strobes: set on the grant edge, held until the edge after
  // pmem_resp. Returning to IDLE first guarantees one idle cycle between
  // transactions, so a request still high in its resp cycle is not regranted.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end else if (grant_d) begin
      // A writeback takes precedence over a read if both are raised.
      pmem_read  <= ~dcache_write;
      pmem_write <= dcache_write;
    end else if (grant_i) begin
      pmem_read  <= 1'b1;
      pmem_write <= 1'b0;
    end else if (state != IDLE && pmem_resp) begin
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Capture registers: requester inputs are only looked at on the grant edge.
  // -------------------------------------------------------------------------
  // NOTE: these data registers are reset even though only the strobes need
  // it, so memory never sees a stale address or line coming out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pmem_address <= '0;
    end else if (grant_d) begin
      pmem_address <= dcache_address;
    end else if (grant_i) begin
      pmem_address <= icache_address;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pmem_wdata <= '0;
    end else if (grant_d) begin
      pmem_wdata <= dcache_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Read data fans out to both caches; only the owner's resp qualifies it.
  // -------------------------------------------------------------------------
  assign icache_rdata = pmem_rdata;
  assign dcache_rdata = pmem_rdata;
  assign arb_busy     = (state != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter
//   Directed bench for cache_mem_arbiter. Inputs change 1 time unit after a
//   rising edge; outputs are sampled on the falling edge or 1 unit after a
//   rising edge. Define ARB_ROUND_ROBIN_EN consistently for RTL and bench.
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;
  import lc3b_types::*;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          icache_read;
  logic [AW-1:0] icache_address;
  logic [LW-1:0] icache_rdata;
  logic          icache_resp;
  logic          dcache_read;
  logic          dcache_write;
  logic [AW-1:0] dcache_address;
  logic [LW-1:0] dcache_wdata;
  logic [LW-1:0] dcache_rdata;
  logic          dcache_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          arb_busy;

  int n_checks = 0;
  int n_fail   = 0;

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_address (dcache_address),
    .dcache_wdata   (dcache_wdata),
    .dcache_rdata   (dcache_rdata),
    .dcache_resp    (dcache_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .arb_busy       (arb_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] actual,
                       input logic [LW-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for either strobe; on expiry record a failed comparison.
  task automatic wait_strobe(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (pmem_read || pmem_write) return;
      tick();
    end
    check({tag, "_timeout"}, LW'(0), LW'(1));
  endtask

  // Pulse pmem_resp for one cycle; report which resp fired (2=D, 1=I).
  task automatic complete(input logic [LW-1:0] rd, output logic [1:0] owner);
    pmem_resp  = 1'b1;
    pmem_rdata = rd;
    @(negedge clk);
    owner = {dcache_resp, icache_resp};
    tick();
    pmem_resp = 1'b0;
  endtask

  logic [1:0]    owner;
  logic [LW-1:0] line_a;
  logic [LW-1:0] line_b;
  logic [1:0]    exp_order [4];

  initial begin
    line_a = {32'hdead_beef, 32'h0123_4567, 32'h89ab_cdef, 32'hcafe_f00d};
    line_b = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};

    reset          = 1'b1;
    icache_read    = 1'b0;
    icache_address = '0;
    dcache_read    = 1'b0;
    dcache_write   = 1'b0;
    dcache_address = '0;
    dcache_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;

    // ---- reset state ------------------------------------------------------
    #2;
    check("rst_pmem_read",  LW'(pmem_read),    LW'(0));
    check("rst_pmem_write", LW'(pmem_write),   LW'(0));
    check("rst_address",    LW'(pmem_address), LW'(0));
    check("rst_wdata",      pmem_wdata,        LW'(0));
    check("rst_busy",       LW'(arb_busy),     LW'(0));
    check("rst_resp",       LW'({icache_resp, dcache_resp}), LW'(0));
    tick();
    reset = 1'b0;
    tick();

    // ---- 1: icache read, resp 3 cycles after strobe -----------------------
    icache_read    = 1'b1;
    icache_address = 16'h1000;
    @(negedge clk);
    check("t1_no_strobe_before_grant", LW'(pmem_read), LW'(0));
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t1_strobe_held", LW'({pmem_read, pmem_write, icache_resp}), LW'(3'b100));
      tick();
    end
    check("t1_address", LW'(pmem_address), LW'(16'h1000));
    pmem_resp  = 1'b1;
    pmem_rdata = line_a;
    @(negedge clk);
    check("t1_strobe_4th_cycle", LW'(pmem_read), LW'(1));
    check("t1_icache_resp", LW'(icache_resp), LW'(1));
    check("t1_dcache_resp", LW'(dcache_resp), LW'(0));
    check("t1_icache_rdata", icache_rdata, line_a);
    tick();
    pmem_resp   = 1'b0;
    icache_read = 1'b0;
    // Request was still high in the resp cycle: must not be regranted.
    check("t1_strobe_dropped", LW'(pmem_read), LW'(0));
    check("t1_idle", LW'(arb_busy), LW'(0));
    check("t1_resp_single", LW'(icache_resp), LW'(0));
    tick();
    check("t1_no_regrant", LW'(pmem_read), LW'(0));

    // ---- 2: icache and dcache writeback raised together -------------------
    icache_read    = 1'b1;
    icache_address = 16'h1000;
    dcache_write   = 1'b1;
    dcache_address = 16'h2000;
    dcache_wdata   = line_b;
    tick();
    check("t2_first_write", LW'({pmem_read, pmem_write}), LW'(2'b01));
    check("t2_first_addr",  LW'(pmem_address), LW'(16'h2000));
    check("t2_wdata",       pmem_wdata, line_b);
    tick();
    complete(line_a, owner);
    check("t2_first_owner", LW'(owner), LW'(2'b10));
    dcache_write = 1'b0;
    check("t2_turnaround_idle", LW'({arb_busy, pmem_read, pmem_write}), LW'(0));
    tick();
    check("t2_second_read", LW'({pmem_read, pmem_write}), LW'(2'b10));
    check("t2_second_addr", LW'(pmem_address), LW'(16'h1000));
    complete(line_b, owner);
    check("t2_second_owner", LW'(owner), LW'(2'b01));
    icache_read = 1'b0;
    tick();

    // ---- 3: both held for four transactions -------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp_order = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    icache_read    = 1'b1;
    icache_address = 16'h1100;
    dcache_read    = 1'b1;
    dcache_address = 16'h2200;
    for (int t = 0; t < 4; t++) begin
      wait_strobe("t3_strobe");
      complete(line_a, owner);
      check($sformatf("t3_owner_%0d", t), LW'(owner), LW'(exp_order[t]));
    end
    icache_read = 1'b0;
    dcache_read = 1'b0;
    tick();
    tick();

    // ---- 4: inputs change and request drops after grant -------------------
    dcache_read    = 1'b1;
    dcache_address = 16'h2000;
    dcache_wdata   = line_a;
    tick();
    check("t4_read_strobe", LW'({pmem_read, pmem_write}), LW'(2'b10));
    dcache_address = 16'h3000;
    dcache_wdata   = line_b;
    dcache_read    = 1'b0;
    tick();
    check("t4_addr_held", LW'(pmem_address), LW'(16'h2000));
    check("t4_wdata_held", pmem_wdata, line_a);
    check("t4_still_busy", LW'({arb_busy, pmem_read}), LW'(2'b11));
    pmem_resp  = 1'b1;
    pmem_rdata = line_b;
    @(negedge clk);
    check("t4_addr_at_resp", LW'(pmem_address), LW'(16'h2000));
    check("t4_dcache_resp", LW'({dcache_resp, icache_resp}), LW'(2'b10));
    check("t4_dcache_rdata", dcache_rdata, line_b);
    tick();
    pmem_resp = 1'b0;
    tick();

    // ---- 5: reset mid SERVE_D (read+write -> write wins) ------------------
    dcache_read    = 1'b1;
    dcache_write   = 1'b1;
    dcache_address = 16'h4000;
    tick();
    check("t5_write_wins", LW'({pmem_read, pmem_write}), LW'(2'b01));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_async_strobes", LW'({pmem_read, pmem_write}), LW'(0));
    check("t5_async_idle", LW'(arb_busy), LW'(0));
    check("t5_addr_cleared", LW'(pmem_address), LW'(0));
    tick();
    reset        = 1'b0;
    dcache_read  = 1'b0;
    dcache_write = 1'b0;
    icache_read    = 1'b1;
    icache_address = 16'h5000;
    @(negedge clk);
    check("t5_new_latency", LW'(pmem_read), LW'(0));
    tick();
    check("t5_new_grant", LW'({pmem_read, pmem_write}), LW'(2'b10));
    check("t5_new_addr", LW'(pmem_address), LW'(16'h5000));
    complete(line_a, owner);
    check("t5_new_owner", LW'(owner), LW'(2'b01));
    icache_read = 1'b0;
    tick();

    // ---- 6: stray pmem_resp while idle ------------------------------------
    pmem_resp = 1'b1;
    @(negedge clk);
    check("t6_no_resp", LW'({icache_resp, dcache_resp}), LW'(0));
    check("t6_not_busy", LW'(arb_busy), LW'(0));
    tick();
    pmem_resp = 1'b0;
    check("t6_still_idle", LW'({arb_busy, pmem_read, pmem_write}), LW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Shares the single physical memory port between the instruction cache and data cache miss/writeback paths of the pipelined LC-3b core. It sits between both caches and physical memory and serves one line-sized transaction at a time. Request attributes are captured at grant, so memory sees stable signals for the whole transaction. The response is steered back to the owning cache only.

Parameters:
ADDR_WIDTH, 16, byte address width of both cache ports and memory.
LINE_WIDTH, 128, width of one cache line transfer.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
icache_read  input  1  icache line read request, level, held until icache_resp
icache_address  input  ADDR_WIDTH  icache request address
icache_rdata  output  LINE_WIDTH  read line to icache
icache_resp  output  1  one-cycle completion pulse to icache
dcache_read  input  1  dcache line read request
dcache_write  input  1  dcache line writeback request
dcache_address  input  ADDR_WIDTH  dcache request address
dcache_wdata  input  LINE_WIDTH  dcache writeback line
dcache_rdata  output  LINE_WIDTH  read line to dcache
dcache_resp  output  1  one-cycle completion pulse to dcache
pmem_read  output  1  memory read strobe
pmem_write  output  1  memory write strobe
pmem_address  output  ADDR_WIDTH  latched transaction address
pmem_wdata  output  LINE_WIDTH  latched writeback line
pmem_rdata  input  LINE_WIDTH  memory read data, valid with pmem_resp
pmem_resp  input  1  memory completion pulse
arb_busy  output  1  high while in SERVE_I or SERVE_D

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Reset value is IDLE. On reset, all outputs are 0 and the latches are cleared.
- IDLE:
  - pmem_read, pmem_write and both resp outputs are 0.
  - If a dcache request is pending and wins priority, go to SERVE_D and capture address, wdata and op.
  - Op capture: dcache_write wins if both dcache_read and dcache_write are high.
  - Else if icache_read is high, go to SERVE_I and capture icache_address.
- Strobe timing: pmem_read/pmem_write are registered. They assert the cycle after the request is seen in IDLE, giving 1 cycle grant latency. They hold constant until pmem_resp.
- SERVE_x on pmem_resp:
  - Owner's resp is 1 combinationally in the same cycle. The other resp stays 0.
  - Next state is IDLE. Strobes drop on the next edge.
- Turnaround: IDLE always lasts at least one cycle between transactions, so a requester's resp-cycle request is never regranted.
- rdata: icache_rdata and dcache_rdata both equal pmem_rdata combinationally. They are meaningful only with the respective resp.
- Latched attributes: pmem_address and pmem_wdata come from the capture registers. Requester input changes after grant are ignored.
- Requester drops its request mid-transaction: the transaction still completes and resp still pulses.
- pmem_resp while in IDLE is ignored; no resp is generated.
- Default priority: dcache over icache when both are pending in IDLE.
- Reset asserted mid-transaction: state goes to IDLE and strobes go to 0 immediately (asynchronous). The in-flight memory transaction is abandoned.

Optional Feature:
ARB_ROUND_ROBIN_EN:
- Defined: a last_grant flop (reset value = icache) records the last owner. When both caches are pending in IDLE, the cache not granted last wins. A single pending requester is granted regardless of the flag.
- Undefined: fixed dcache-over-icache priority and no last_grant flop.

Decomposition:
- Add to lc3b_types: lc3b_line (128-bit) and enum arb_state_t {IDLE, SERVE_I, SERVE_D}.
- No sub-module. Capture registers are local always_ff blocks with asynchronous reset; the shared register module has no reset.

Test Plan:
- icache_read at 0x1000, pmem_resp 3 cycles after strobe → pmem_read high 4 cycles and pmem_address=0x1000. icache_resp pulses 1 cycle with icache_rdata=pmem_rdata; dcache_resp stays 0.
- icache_read 0x1000 and dcache_write 0x2000 raised together → first pmem_write with address 0x2000 and wdata latched. Then one IDLE cycle, then pmem_read with address 0x1000.
- Both requesters held high for 4 transactions → with ARB_ROUND_ROBIN_EN, owner order D,I,D,I. Without it, D,D,D,D while dcache stays pending.
- dcache_address changes 0x2000→0x3000 after grant → pmem_address stays 0x2000 until resp.
- reset pulsed mid SERVE_D → strobes 0 in the same cycle and state IDLE. A new icache_read afterwards is granted with normal 1-cycle latency.
- pmem_resp pulsed in IDLE with no requests → no resp output and arb_busy stays 0.
